// File: rtl/csr_access_sequencer.sv
// CSR access sequencer: turns one decoded CSR instruction into a read of the
// CSR file, an optional read-modify-write, and a single writeback response.
// Optional feature macro: CSR_RO_CHECK_EN (blocks writes to read-only CSRs,
// addr[11:10] == 2'b11, and flags the response as illegal).
module csr_access_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [11:0]     req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            csr_access_o,
    output logic [1:0]      csr_op_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic [4:0]      rsp_rd_o,
    output logic            rsp_illegal_o
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned RD_W   = 5;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    csr_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic              ready_q, ready_d;
    logic              access_q, access_d;
    csr_op_e           csr_op_q, csr_op_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              write_needed;
    logic              ro_block;
    logic [XLEN-1:0]   merged_wdata;

    // SET/CLEAR with a zero operand is a pure read; WRITE always writes.
    assign write_needed = (op_q == CSR_OP_WRITE) ||
                          (((op_q == CSR_OP_SET) || (op_q == CSR_OP_CLEAR)) && (wdata_q != '0));

`ifdef CSR_RO_CHECK_EN
    logic illegal_q, illegal_d;
    assign ro_block      = (addr_q[11:10] == 2'b11);
    assign rsp_illegal_o = illegal_q;
`else
    assign ro_block      = 1'b0;
    assign rsp_illegal_o = 1'b0;
`endif

    // Read-modify-write merge against the value being read this cycle.
    always_comb begin
        merged_wdata = '0;
        unique case (op_q)
            CSR_OP_WRITE: merged_wdata = wdata_q;
            CSR_OP_SET:   merged_wdata = csr_rdata_i | wdata_q;
            CSR_OP_CLEAR: merged_wdata = csr_rdata_i & ~wdata_q;
            default:      merged_wdata = '0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered from state_d.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        old_d       = old_q;
        csr_op_d    = CSR_OP_NONE;
        csr_wdata_d = '0;
`ifdef CSR_RO_CHECK_EN
        illegal_d   = illegal_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q && !flush_i) begin
                    op_d    = csr_op_e'(req_op_i);
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rd_d    = req_rd_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    old_d = csr_rdata_i;
`ifdef CSR_RO_CHECK_EN
                    illegal_d = write_needed && ro_block;
`endif
                    if (write_needed && !ro_block) begin
                        state_d     = WRITE;
                        csr_op_d    = op_q;
                        csr_wdata_d = merged_wdata;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d     = (state_d == IDLE);
        access_d    = (state_d == READ) || (state_d == WRITE);
        rsp_valid_d = (state_d == RESP);
    end

    // State, request latches and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= CSR_OP_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            old_q       <= '0;
            ready_q     <= 1'b0;
            access_q    <= 1'b0;
            csr_op_q    <= CSR_OP_NONE;
            csr_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            old_q       <= old_d;
            ready_q     <= ready_d;
            access_q    <= access_d;
            csr_op_q    <= csr_op_d;
            csr_wdata_q <= csr_wdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef CSR_RO_CHECK_EN
    // Illegal flag for the pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    assign req_ready_o  = ready_q;
    assign csr_access_o = access_q;
    assign csr_op_o     = csr_op_q;
    assign csr_addr_o   = addr_q;
    assign csr_wdata_o  = csr_wdata_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = old_q;
    assign rsp_rd_o     = rd_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Scoreboard bench for csr_access_sequencer: a CSR-file model answers reads,
// a reference model predicts writes and responses, a monitor compares them.
`timescale 1ns/1ps
module tb_csr_access_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      req_op_i;
    logic [11:0]     req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic [4:0]      req_rd_i;
    logic            flush_i;
    logic            csr_access_o;
    logic [1:0]      csr_op_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic [XLEN-1:0] csr_rdata_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic [4:0]      rsp_rd_o;
    logic            rsp_illegal_o;

    csr_access_sequencer #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .flush_i      (flush_i),
        .csr_access_o (csr_access_o),
        .csr_op_o     (csr_op_o),
        .csr_addr_o   (csr_addr_o),
        .csr_wdata_o  (csr_wdata_o),
        .csr_rdata_i  (csr_rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_rd_o     (rsp_rd_o),
        .rsp_illegal_o(rsp_illegal_o)
    );

    typedef struct {
        logic [11:0]     addr;
        logic [1:0]      op;
        logic [XLEN-1:0] data;
    } wexp_t;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic [4:0]      rd;
        logic            illegal;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];

    logic [XLEN-1:0] env_mem   [4096];
    logic [XLEN-1:0] model_mem [4096];

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // CSR file environment: combinational read data, write on a write strobe.
    assign csr_rdata_i = (csr_access_o && csr_op_o == 2'b00) ? env_mem[csr_addr_o] : 32'hDEAD_BEEF;
    always @(negedge clk) begin
        if (rst_n && csr_access_o && csr_op_o != 2'b00) env_mem[csr_addr_o] = csr_wdata_o;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    // Writeback ready: random, forced low, or forced high.
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready_i = ($urandom_range(0, 3) != 0);
                1:       rsp_ready_i = 1'b0;
                default: rsp_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: compare CSR writes and responses against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (csr_access_o && csr_op_o != 2'b00) begin
                    if (wq.size() == 0) begin
                        fail_event("unexpected_write");
                    end else begin
                        wexp_t w;
                        w = wq.pop_front();
                        check("write_addr", 64'(csr_addr_o), 64'(w.addr));
                        check("write_op", 64'(csr_op_o), 64'(w.op));
                        check("write_data", 64'(csr_wdata_o), 64'(w.data));
                    end
                end else if (!csr_access_o) begin
                    check("quiet_bus", 64'({csr_op_o, csr_wdata_o}), 64'd0);
                end
                if (rsp_valid_o) begin
                    if (rq.size() == 0) begin
                        fail_event("unexpected_rsp");
                    end else begin
                        check("rsp_rdata", 64'(rsp_rdata_o), 64'(rq[0].rdata));
                        check("rsp_rd", 64'(rsp_rd_o), 64'(rq[0].rd));
                        check("rsp_illegal", 64'(rsp_illegal_o), 64'(rq[0].illegal));
                        if (rsp_ready_i) void'(rq.pop_front());
                    end
                end
            end
        end
    end

    // Reference model. mode 0: normal, 1: flushed in READ, 2: reset during WRITE.
    task automatic model_req(input logic [1:0] op, input logic [11:0] addr,
                             input logic [XLEN-1:0] wd, input logic [4:0] rd, input int mode);
        logic [XLEN-1:0] old;
        logic [XLEN-1:0] nv;
        bit wr;
        bit ro;
        old = model_mem[addr];
        wr  = (op == 2'b01) || (op != 2'b00 && wd != 0);
        ro  = 1'b0;
`ifdef CSR_RO_CHECK_EN
        ro  = (addr[11:10] == 2'b11);
`endif
        if (mode == 1) return;
        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            2'b11:   nv = old & ~wd;
            default: nv = old;
        endcase
        if (wr && !ro) begin
            wq.push_back('{addr: addr, op: op, data: nv});
            model_mem[addr] = nv;
        end
        if (mode == 0) rq.push_back('{rdata: old, rd: rd, illegal: wr && ro});
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready_o) begin
            if (k == 300) begin
                $display("FAIL ready_timeout: req_ready_o stuck at 0 after %0d cycles", k);
                $fatal(1, "ready timeout");
            end
            k++;
            @(negedge clk);
        end
    endtask

    // Present one request; returns at the negedge of the READ cycle.
    task automatic issue(input logic [1:0] op, input logic [11:0] addr,
                         input logic [XLEN-1:0] wd, input logic [4:0] rd, input int mode);
        wait_ready();
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_rd_i    = rd;
        model_req(op, addr, wd, rd, mode);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_op_i    = 2'($urandom);
        req_addr_i  = 12'($urandom);
        req_wdata_i = $urandom;
        req_rd_i    = 5'($urandom);
    endtask

    initial begin
        logic [11:0] pool [6];
        logic [XLEN-1:0] v;
        int k;
        pool = '{12'h300, 12'h301, 12'h340, 12'h7C0, 12'hC00, 12'hC01};
        for (int i = 0; i < 4096; i++) begin
            v = $urandom;
            env_mem[i]   = v;
            model_mem[i] = v;
        end
        env_mem[12'h300]   = 32'h1;
        model_mem[12'h300] = 32'h1;

        rst_n = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0;
        req_wdata_i = '0; req_rd_i = '0; flush_i = 1'b0;
        #1 rst_n = 1'b0;
        #4;
        check("reset_ctl", 64'({req_ready_o, csr_access_o, csr_op_o, rsp_valid_o, rsp_illegal_o}), 64'd0);
        check("reset_addr_rd", 64'({csr_addr_o, rsp_rd_o}), 64'd0);
        check("reset_data", 64'({csr_wdata_o, rsp_rdata_o}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // SET 0x300 with 0x8 over old value 0x1.
        issue(2'b10, 12'h300, 32'h8, 5'd5, 0);
        check("set_read_strobe", 64'({csr_access_o, csr_op_o, csr_addr_o}), 64'({1'b1, 2'b00, 12'h300}));
        @(negedge clk);
        check("set_write_op", 64'({csr_access_o, csr_op_o}), 64'({1'b1, 2'b10}));
        check("set_write_data", 64'(csr_wdata_o), 64'h9);
        @(negedge clk);
        check("set_rsp", 64'({rsp_valid_o, rsp_rdata_o, rsp_rd_o}), 64'({1'b1, 32'h1, 5'd5}));

        // CLEAR with zero operand: read only, response one cycle earlier.
        issue(2'b11, 12'h340, 32'h0, 5'd7, 0);
        check("clr0_read", 64'(csr_access_o), 64'd1);
        @(negedge clk);
        check("clr0_no_write", 64'({csr_access_o, rsp_valid_o}), 64'({1'b0, 1'b1}));

        // Writeback stalls for four cycles.
        issue(2'b01, 12'h341, $urandom, 5'd9, 0);
        rdy_mode = 1;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("stall_hold", 64'({rsp_valid_o, req_ready_o}), 64'({1'b1, 1'b0}));
        end
        rdy_mode = 2;
        @(negedge clk);
        check("stall_release", 64'({rsp_valid_o, req_ready_o}), 64'({1'b0, 1'b1}));
        rdy_mode = 0;

        // Flush in IDLE blocks acceptance.
        wait_ready();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 12'h301; flush_i = 1'b1;
        @(negedge clk);
        check("idle_flush_block", 64'({csr_access_o, req_ready_o}), 64'({1'b0, 1'b1}));
        req_valid_i = 1'b0; flush_i = 1'b0;

        // Flush in READ aborts; flush in WRITE is ignored.
        issue(2'b01, 12'h342, $urandom, 5'd3, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("read_flush_abort", 64'({csr_access_o, rsp_valid_o, req_ready_o}), 64'({1'b0, 1'b0, 1'b1}));
        issue(2'b01, 12'h342, $urandom, 5'd4, 0);
        @(negedge clk);
        flush_i = 1'b1;
        check("write_flush_op", 64'({csr_access_o, csr_op_o}), 64'({1'b1, 2'b01}));
        @(negedge clk);
        flush_i = 1'b0;
        check("write_flush_rsp", 64'(rsp_valid_o), 64'd1);

        // WRITE to a read-only address.
        issue(2'b01, 12'hC00, 32'h1234_5678, 5'd11, 0);
        @(negedge clk);
`ifdef CSR_RO_CHECK_EN
        check("ro_blocked", 64'({csr_access_o, rsp_valid_o, rsp_illegal_o}), 64'({1'b0, 1'b1, 1'b1}));
`else
        check("ro_written", 64'({csr_access_o, csr_op_o, rsp_illegal_o}), 64'({1'b1, 2'b01, 1'b0}));
`endif

        // Reset pulse in the middle of a WRITE cycle.
        issue(2'b01, 12'h305, $urandom, 5'd13, 2);
        @(negedge clk);
        check("pre_reset_write", 64'({csr_access_o, csr_op_o}), 64'({1'b1, 2'b01}));
        #4 rst_n = 1'b0;
        #1;
        check("async_reset_ctl", 64'({req_ready_o, csr_access_o, csr_op_o, rsp_valid_o, rsp_illegal_o}), 64'd0);
        check("async_reset_data", 64'({csr_wdata_o, rsp_rdata_o}), 64'd0);
        check("async_reset_addr", 64'({csr_addr_o, rsp_rd_o}), 64'd0);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("post_reset_no_rsp", 64'(rsp_valid_o), 64'd0);
        end

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            logic [11:0] addr;
            logic [XLEN-1:0] wd;
            int sel;
            op   = 2'($urandom_range(0, 3));
            addr = pool[$urandom_range(0, 5)];
            wd   = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            sel  = $urandom_range(0, 9);
            issue(op, addr, wd, 5'($urandom), (sel == 0) ? 1 : 0);
            if (sel == 0) begin
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end else if (sel == 1) begin
                @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        end

        k = 0;
        while ((wq.size() != 0 || rq.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_writes", 64'(wq.size()), 64'd0);
        check("drain_rsps", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_access_sequencer.md
CSR_ACCESS_SEQUENCER -- requirements
Module: csr_access_sequencer

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, CSR data width.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  decoder presents a CSR instruction.
REQ-005 req_ready_o  output  1  sequencer can accept a request.
REQ-006 req_op_i  input  2  00 NONE (read only), 01 WRITE, 10 SET, 11 CLEAR.
REQ-007 req_addr_i  input  12  CSR address.
REQ-008 req_wdata_i  input  XLEN  source operand (rs1 value or zimm).
REQ-009 req_rd_i  input  5  destination register index.
REQ-010 flush_i  input  1  pipeline flush from controller.
REQ-011 csr_access_o  output  1  CSR file access strobe.
REQ-012 csr_op_o  output  2  op to CSR file; 00 = CSR_OP_NONE (read).
REQ-013 csr_addr_o  output  12  CSR address to CSR file.
REQ-014 csr_wdata_o  output  XLEN  final write data to CSR file.
REQ-015 csr_rdata_i  input  XLEN  CSR read data, valid in the same cycle as a read access.
REQ-016 rsp_valid_o  output  1  response to writeback valid.
REQ-017 rsp_ready_i  input  1  writeback accepts response.
REQ-018 rsp_rdata_o  output  XLEN  old CSR value (written to rd).
REQ-019 rsp_rd_o  output  5  rd index of the response.
REQ-020 rsp_illegal_o  output  1  request raised an illegal-instruction condition.

Function
REQ-021 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-022 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i & req_ready_o, latching op, addr, wdata and rd; IDLE->READ.
REQ-023 READ SHALL drive csr_access_o=1, csr_op_o=00, csr_addr_o=latched addr; csr_rdata_i is captured into the old-value register at the end of the cycle.
REQ-024 READ->WRITE when op is WRITE, or when op is SET/CLEAR with latched wdata != 0; otherwise READ->RESP with no write issued.
REQ-025 WRITE SHALL drive csr_access_o=1 and csr_op_o=latched op for exactly one cycle, with csr_wdata_o = wdata (WRITE), old|wdata (SET), old&~wdata (CLEAR); WRITE->RESP.
REQ-026 Outside READ/WRITE, csr_access_o=0, csr_op_o=00 and csr_wdata_o=0.
REQ-027 RESP SHALL hold rsp_valid_o=1 with stable rsp_rdata_o, rsp_rd_o and rsp_illegal_o until rsp_ready_i=1; then RESP->IDLE.
REQ-028 Latency: accept at cycle N -> READ N+1 -> WRITE N+2 (if issued) -> rsp_valid_o from N+3 (N+2 with no write).
REQ-029 flush_i in READ SHALL abort to IDLE with no write and no response; flush_i in WRITE or RESP SHALL be ignored, because the write is committed; flush_i in IDLE SHALL block acceptance that cycle.
REQ-030 A new request SHALL NOT be accepted in the same cycle that RESP completes; req_ready_o rises the following cycle.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously force IDLE, and every output and latched register SHALL go to 0; csr_op_o SHALL reset to CSR_OP_NONE, and no register is left unreset.
REQ-032 A reset asserted in READ or WRITE SHALL abort the access, with csr_access_o=0 immediately, and no response SHALL follow.

Configuration
REQ-033 Macro CSR_RO_CHECK_EN, when defined: a request whose addr[11:10]==2'b11 and whose write would be issued per REQ-024 SHALL skip WRITE and return rsp_illegal_o=1, with rsp_rdata_o still carrying the old value.
REQ-034 When CSR_RO_CHECK_EN is undefined, rsp_illegal_o SHALL be tied 0 and read-only addresses SHALL be written like any other.

Verification
REQ-035 SET addr 0x300, wdata 0x8, csr_rdata_i 0x1 -> csr_op_o 10 at N+2 with csr_wdata_o 0x9; rsp_rdata_o 0x1 at N+3.
REQ-036 CLEAR wdata 0 -> no WRITE cycle, so csr_access_o is high for one cycle only; rsp_valid_o at N+2.
REQ-037 WRITE, rsp_ready_i held 0 for 4 cycles -> rsp_valid_o and data stable for 4 cycles, and req_ready_o stays 0 until one cycle after the handshake.
REQ-038 flush_i in READ -> no WRITE, no rsp_valid_o, and req_ready_o=1 the next cycle; flush_i in WRITE -> write issued and response delivered.
REQ-039 With CSR_RO_CHECK_EN, WRITE to 0xC00 -> no op 01 on csr_op_o and rsp_illegal_o=1; without it -> write issued and rsp_illegal_o=0.
REQ-040 rst_n pulsed low mid-WRITE -> all outputs 0 asynchronously, state IDLE, and no response after release.
